// File: rtl/rca4.sv
// ============================================================================
// rca4 : registered WIDTH-bit ripple-carry adder built from 1-bit full adders
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module rca4_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module rca4 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   logic [WIDTH:0]   w_c;
   logic [WIDTH-1:0] w_s;

   assign w_c[0] = cin;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_fa
         rca4_fa u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (w_c[i]),
            .s  (w_s[i]),
            .co (w_c[i+1])
         );
      end
   endgenerate

   // Signed overflow: carry into the sign bit disagrees with carry out of it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum  <= '0;
         cout <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         sum  <= w_s;
         cout <= w_c[WIDTH];
         ovf  <= w_c[WIDTH] ^ w_c[WIDTH-1];
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_rca4.sv
// ============================================================================
// tb_rca4 : directed and exhaustive checks of the registered ripple-carry adder
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_rca4;
   logic       clk;
   logic       rst_n;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic [3:0] sum;
   logic       cout;
   logic       ovf;

   int checks;
   int failures;

   rca4 #(.WIDTH(4)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed/expected are packed as {ovf, cout, sum}.
   task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got ovf=%b cout=%b sum=%h, want ovf=%b cout=%b sum=%h",
                  tag, obs[5], obs[4], obs[3:0], exp[5], exp[4], exp[3:0]);
      end
   endtask

   task automatic drive(input logic [3:0] va, input logic [3:0] vb, input logic vc);
      @(negedge clk);
      a   = va;
      b   = vb;
      cin = vc;
   endtask

   // Drive on the falling edge, check just after the capturing rising edge.
   task automatic add_check(input string tag, input logic [3:0] va, input logic [3:0] vb,
                            input logic vc, input logic [5:0] exp);
      drive(va, vb, vc);
      @(posedge clk);
      #1;
      check(tag, {ovf, cout, sum}, exp);
   endtask

   function automatic logic [5:0] model(input logic [3:0] va, input logic [3:0] vb, input logic vc);
      logic [4:0] t;
      logic       v;
      t = {1'b0, va} + {1'b0, vb} + {4'b0, vc};
      v = (va[3] == vb[3]) && (t[3] != va[3]);
      return {v, t[4], t[3:0]};
   endfunction

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      a        = 4'hF;
      b        = 4'hF;
      cin      = 1'b1;

      #2;
      check("reset_no_edge", {ovf, cout, sum}, 6'b00_0000);
      @(posedge clk);
      #1;
      check("reset_hold", {ovf, cout, sum}, 6'b00_0000);

      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors, expectations worked by hand.
      add_check("basic",       4'h1, 4'h2, 1'b0, {1'b0, 1'b0, 4'h3});
      add_check("carry_in",    4'h1, 4'h2, 1'b1, {1'b0, 1'b0, 4'h4});
      add_check("carry_out",   4'h7, 4'h9, 1'b1, {1'b0, 1'b1, 4'h1});
      add_check("full_ripple", 4'hF, 4'h0, 1'b1, {1'b0, 1'b1, 4'h0});
      add_check("pos_ovf",     4'h7, 4'h1, 1'b0, {1'b1, 1'b0, 4'h8});
      add_check("neg_ovf",     4'h8, 4'h8, 1'b0, {1'b1, 1'b1, 4'h0});
      add_check("max_case",    4'hF, 4'hF, 1'b1, {1'b0, 1'b1, 4'hF});
      add_check("zero",        4'h0, 4'h0, 1'b0, {1'b0, 1'b0, 4'h0});
      add_check("neg_no_ovf",  4'hC, 4'h3, 1'b0, {1'b0, 1'b0, 4'hF});

      // Inputs changed between edges must not reach the registered outputs.
      add_check("hold_base",   4'h5, 4'h6, 1'b0, {1'b1, 1'b0, 4'hB});
      a   = 4'h0;
      b   = 4'h1;
      cin = 1'b0;
      #2;
      check("hold_between_edges", {ovf, cout, sum}, {1'b1, 1'b0, 4'hB});

      // Async reset mid-stream clears outputs at once, no clock edge needed.
      drive(4'h9, 4'h9, 1'b1);
      @(posedge clk);
      #1;
      check("pre_reset", {ovf, cout, sum}, {1'b1, 1'b1, 4'h3});
      drive(4'hE, 4'h3, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_reset", {ovf, cout, sum}, 6'b00_0000);
      @(posedge clk);
      #1;
      check("reset_discard", {ovf, cout, sum}, 6'b00_0000);
      @(negedge clk);
      rst_n = 1'b1;
      a     = 4'h2;
      b     = 4'h3;
      cin   = 1'b1;
      #1;
      check("release_no_edge", {ovf, cout, sum}, 6'b00_0000);
      @(posedge clk);
      #1;
      check("resume", {ovf, cout, sum}, {1'b0, 1'b0, 4'h6});

      // Exhaustive sweep, one new vector each cycle.
      for (int i = 0; i < 512; i++) begin
         logic [8:0] v;
         v = i[8:0];
         add_check("exhaustive", v[3:0], v[7:4], v[8], model(v[3:0], v[7:4], v[8]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running, want finished");
      $fatal(1);
   end
endmodule

`default_nettype wire
